// File: rtl/spi_slave_core.sv
// ---------------------------------------------------------------------------
// spi_slave_core
//
// SPI slave front end for the logic analyser command path. Supports all four
// SPI modes (CPOL/CPHA), a configurable long-command length and a full-duplex
// transmit path with per-byte valid masking.
//
// Ports:
//   clock        system clock, all logic on posedge
//   extReset_n   asynchronous active-low reset
//   cs_n         SPI chip select (active low, asynchronous)
//   sclk         SPI clock (asynchronous, <= clock/8)
//   mosi         SPI data in, MSB first
//   miso         SPI data out, MSB first (0 when idle)
//   send         request to transmit send_data (taken only when busy=0)
//   send_data    transmit word, byte k in [8k+7:8k]
//   send_valid   per-byte transmit enable mask
//   cmd          last complete command, opcode in [7:0]
//   execute      1-cycle pulse when cmd is updated
//   busy         transmit word in flight
//   byte_done    1-cycle pulse after each transmitted byte
//   overrun      1-cycle pulse when send arrives while busy
//   frame_abort  1-cycle pulse when cs_n rises on a partial rx/tx frame
// ---------------------------------------------------------------------------
module spi_slave_core #(
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int CMD_BYTES   = 5,
    parameter int TX_BYTES    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   extReset_n,
    input  logic                   cs_n,
    input  logic                   sclk,
    input  logic                   mosi,
    output logic                   miso,
    input  logic                   send,
    input  logic [8*TX_BYTES-1:0]  send_data,
    input  logic [TX_BYTES-1:0]    send_valid,
    output logic [8*CMD_BYTES-1:0] cmd,
    output logic                   execute,
    output logic                   busy,
    output logic                   byte_done,
    output logic                   overrun,
    output logic                   frame_abort
);

    localparam int IW = $clog2(CMD_BYTES);

    // Lowest-indexed enabled byte of a word; bytes go out in ascending order.
    function automatic logic [7:0] f_pick(input logic [8*TX_BYTES-1:0] d,
                                          input logic [TX_BYTES-1:0]   m);
        logic [7:0] b;
        b = '0;
        for (int k = TX_BYTES - 1; k >= 0; k--) begin
            if (m[k]) b = d[8*k +: 8];
        end
        return b;
    endfunction

    // -----------------------------------------------------------------------
    // Synchronisers and edge detection
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    // sclk chain resets to its idle level so release from reset is not
    // mistaken for an edge; cs_n chain resets to deselected.
    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            r_sclk_sync <= (CPOL != 0) ? '1 : '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= (CPOL != 0);
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    logic w_sclk_s, w_cs_s, w_mosi_s;
    logic w_rise, w_fall, w_lead, w_trail;
    logic w_cs_act, w_sample, w_shift, w_cs_rise;

    assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise    = w_sclk_s & ~r_sclk_d;
    assign w_fall    = ~w_sclk_s & r_sclk_d;
    assign w_lead    = (CPOL == 0) ? w_rise : w_fall;
    assign w_trail   = (CPOL == 0) ? w_fall : w_rise;
    assign w_cs_act  = ~w_cs_s;
    assign w_sample  = w_cs_act & ((CPHA == 0) ? w_lead : w_trail);
    assign w_shift   = w_cs_act & ((CPHA == 0) ? w_trail : w_lead);
    assign w_cs_rise = w_cs_s & ~r_cs_d;

    // -----------------------------------------------------------------------
    // Receive path
    // -----------------------------------------------------------------------
    logic [2:0]                 r_rx_bit;
    logic [6:0]                 r_rx_sr;
    logic [IW-1:0]              r_rx_idx;
    logic [CMD_BYTES-2:0][7:0]  r_frame;   // bytes 0..CMD_BYTES-2; the last one arrives live
    logic [8*CMD_BYTES-1:0]     r_cmd;
    logic                       r_execute;

    logic [7:0] w_rx_byte;
    logic       w_byte_end;
    logic       w_rx_done;
    logic       w_rx_partial;

    assign w_rx_byte    = {r_rx_sr, w_mosi_s};
    assign w_byte_end   = w_sample && (r_rx_bit == 3'd7);
    // Short frame: opcode with bit 7 clear. Long frame: CMD_BYTES bytes.
    assign w_rx_done    = w_byte_end &&
                          (((r_rx_idx == '0) && !w_rx_byte[7]) ||
                           (r_rx_idx == IW'(CMD_BYTES - 1)));
    assign w_rx_partial = (r_rx_bit != 3'd0) || (r_rx_idx != '0);

    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            r_rx_bit  <= '0;
            r_rx_sr   <= '0;
            r_rx_idx  <= '0;
            r_frame   <= '0;
            r_cmd     <= '0;
            r_execute <= 1'b0;
        end else begin
            r_execute <= w_rx_done;
            if (w_sample) begin
                r_rx_sr  <= {r_rx_sr[5:0], w_mosi_s};
                r_rx_bit <= r_rx_bit + 3'd1;
                if (w_rx_done) begin
                    r_rx_idx <= '0;
                    if (r_rx_idx == '0)
                        r_cmd <= {{(8*(CMD_BYTES-1)){1'b0}}, w_rx_byte};
                    else
                        r_cmd <= {w_rx_byte, r_frame};
                end else if (w_byte_end) begin
                    for (int k = 0; k < CMD_BYTES - 1; k++) begin
                        if (r_rx_idx == IW'(k)) r_frame[k] <= w_rx_byte;
                    end
                    r_rx_idx <= r_rx_idx + 1'b1;
                end
            end else if (w_cs_rise) begin
                // Deselect drops any partial frame; cmd keeps its old value.
                r_rx_bit <= '0;
                r_rx_idx <= '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Transmit path
    // -----------------------------------------------------------------------
    logic [8*TX_BYTES-1:0] r_tx_data;
    logic [TX_BYTES-1:0]   r_tx_mask;  // bytes still to send, current one included
    logic [7:0]            r_tx_sr;
    logic [2:0]            r_tx_bit;   // bits sampled by the master in this byte
    logic                  r_busy;
    logic                  r_miso;
    logic                  r_byte_done;
    logic                  r_overrun;
    logic                  r_abort;

    logic                  w_accept;
    logic                  w_abort;
    logic [TX_BYTES-1:0]   w_rest;
    logic [7:0]            w_first;
    logic [7:0]            w_next;

    assign w_accept = send && !r_busy && (send_valid != '0);
    // A frame completing in the same cycle as deselect takes priority.
    assign w_abort  = w_cs_rise && !w_rx_done && (w_rx_partial || r_busy);
    assign w_rest   = r_tx_mask & (r_tx_mask - 1'b1);  // drop current byte
    assign w_first  = f_pick(send_data, send_valid);
    assign w_next   = f_pick(r_tx_data, w_rest);

    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            r_tx_data   <= '0;
            r_tx_mask   <= '0;
            r_tx_sr     <= '0;
            r_tx_bit    <= '0;
            r_busy      <= 1'b0;
            r_miso      <= 1'b0;
            r_byte_done <= 1'b0;
            r_overrun   <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_overrun   <= send && r_busy;
            r_abort     <= w_abort;
            r_byte_done <= r_busy && w_sample && (r_tx_bit == 3'd7);
            if (w_accept) begin
                r_tx_data <= send_data;
                r_tx_mask <= send_valid;
                r_tx_bit  <= '0;
                r_busy    <= 1'b1;
                // CPHA=0 presents the MSB before the first sample edge;
                // CPHA=1 waits for the first shift edge.
                if (CPHA == 0) begin
                    r_miso  <= w_first[7];
                    r_tx_sr <= {w_first[6:0], 1'b0};
                end else begin
                    r_miso  <= 1'b0;
                    r_tx_sr <= w_first;
                end
            end else if (w_abort) begin
                r_tx_mask <= '0;
                r_tx_bit  <= '0;
                r_busy    <= 1'b0;
                r_miso    <= 1'b0;
            end else if (r_busy) begin
                if (w_sample) begin
                    r_tx_bit <= r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7) begin
                        r_tx_mask <= w_rest;
                        if (w_rest == '0) begin
                            r_busy <= 1'b0;
                            r_miso <= 1'b0;
                        end else if (CPHA == 0) begin
                            r_miso  <= w_next[7];
                            r_tx_sr <= {w_next[6:0], 1'b0};
                        end else begin
                            r_tx_sr <= w_next;
                        end
                    end
                end else if (w_shift && ((CPHA != 0) || (r_tx_bit != 3'd0))) begin
                    // With CPHA=0 the shift edge following a byte's last
                    // sample must not disturb the already-presented MSB.
                    r_miso  <= r_tx_sr[7];
                    r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                end
            end
        end
    end

    assign miso        = r_miso;
    assign cmd         = r_cmd;
    assign execute     = r_execute;
    assign busy        = r_busy;
    assign byte_done   = r_byte_done;
    assign overrun     = r_overrun;
    assign frame_abort = r_abort;

endmodule

// File: tb/tb_spi_slave_core.sv
module tb_spi_slave_core;

    localparam int HALF = 8;  // sclk half period in system clocks

    logic        clock = 1'b0;
    logic        extReset_n, cs_n, mosi, sclk_a, sclk_b, send_a, send_b;
    logic [31:0] send_data;
    logic [3:0]  send_valid;
    logic        miso_a, execute_a, busy_a, byte_done_a, overrun_a, frame_abort_a;
    logic        miso_b, execute_b, busy_b, byte_done_b, overrun_b, frame_abort_b;
    logic [39:0] cmd_a, cmd_b;

    always #5 clock = ~clock;

    // Mode 0 instance (a) and mode 3 instance (b) share cs_n / mosi.
    spi_slave_core #(.CPOL(0), .CPHA(0), .CMD_BYTES(5), .TX_BYTES(4), .SYNC_STAGES(2)) u_m0 (
        .clock(clock), .extReset_n(extReset_n), .cs_n(cs_n), .sclk(sclk_a), .mosi(mosi),
        .miso(miso_a), .send(send_a), .send_data(send_data), .send_valid(send_valid),
        .cmd(cmd_a), .execute(execute_a), .busy(busy_a), .byte_done(byte_done_a),
        .overrun(overrun_a), .frame_abort(frame_abort_a));

    spi_slave_core #(.CPOL(1), .CPHA(1), .CMD_BYTES(5), .TX_BYTES(4), .SYNC_STAGES(2)) u_m3 (
        .clock(clock), .extReset_n(extReset_n), .cs_n(cs_n), .sclk(sclk_b), .mosi(mosi),
        .miso(miso_b), .send(send_b), .send_data(send_data), .send_valid(send_valid),
        .cmd(cmd_b), .execute(execute_b), .busy(busy_b), .byte_done(byte_done_b),
        .overrun(overrun_b), .frame_abort(frame_abort_b));

    // Pulse monitors
    int   n_exec_a, n_exec_b, n_bd_a, n_bd_b, n_ovr_a, n_ovr_b, n_abt_a, n_abt_b;
    logic bd_busy_last_a = 1'b0, bd_busy_prev_a = 1'b0;

    always @(negedge clock) begin
        if (execute_a)     n_exec_a <= n_exec_a + 1;
        if (execute_b)     n_exec_b <= n_exec_b + 1;
        if (byte_done_b)   n_bd_b   <= n_bd_b + 1;
        if (overrun_a)     n_ovr_a  <= n_ovr_a + 1;
        if (overrun_b)     n_ovr_b  <= n_ovr_b + 1;
        if (frame_abort_a) n_abt_a  <= n_abt_a + 1;
        if (frame_abort_b) n_abt_b  <= n_abt_b + 1;
        if (byte_done_a) begin
            n_bd_a         <= n_bd_a + 1;
            bd_busy_prev_a <= bd_busy_last_a;
            bd_busy_last_a <= busy_a;
        end
    end

    int          checks = 0, errors = 0;
    logic [7:0]  mo_q[$], mi_q[$], exp_q[$];

    function automatic int c_exec(input int m); return (m == 0) ? n_exec_a : n_exec_b; endfunction
    function automatic int c_bd  (input int m); return (m == 0) ? n_bd_a   : n_bd_b;   endfunction
    function automatic int c_ovr (input int m); return (m == 0) ? n_ovr_a  : n_ovr_b;  endfunction
    function automatic int c_abt (input int m); return (m == 0) ? n_abt_a  : n_abt_b;  endfunction
    function automatic logic [39:0] g_cmd(input int m); return (m == 0) ? cmd_a : cmd_b; endfunction
    function automatic logic g_busy(input int m); return (m == 0) ? busy_a : busy_b; endfunction
    function automatic logic g_miso(input int m); return (m == 0) ? miso_a : miso_b; endfunction

    // Reference: opcode bit 7 picks short (1 byte) or long (5 bytes) frame.
    function automatic logic [39:0] exp_cmd();
        logic [39:0] r;
        r = '0;
        if (!mo_q[0][7]) r[7:0] = mo_q[0];
        else for (int k = 0; k < 5; k++) r[8*k +: 8] = mo_q[k];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n); repeat (n) @(negedge clock); endtask

    task automatic tog(input int m);
        if (m == 0) sclk_a = ~sclk_a; else sclk_b = ~sclk_b;
    endtask

    // Master: shifts nb bits of mo MSB first, samples miso on the sample edge.
    task automatic spi_bits(input int m, input logic [7:0] mo, input int nb, output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i > 7 - nb; i--) begin
            if (m == 0) begin
                mosi = mo[i]; clk_n(HALF); mi[i] = miso_a; tog(m); clk_n(HALF); tog(m);
            end else begin
                tog(m); mosi = mo[i]; clk_n(HALF); mi[i] = miso_b; tog(m); clk_n(HALF);
            end
        end
    endtask

    task automatic xfer(input int m);
        logic [7:0] mi;
        int a0;
        a0 = c_abt(m);
        mi_q.delete();
        cs_n = 1'b0; clk_n(4);
        foreach (mo_q[k]) begin
            spi_bits(m, mo_q[k], 8, mi);
            mi_q.push_back(mi);
        end
        clk_n(HALF); cs_n = 1'b1; clk_n(8);
        chk("no_abort_on_boundary", 64'(c_abt(m) - a0), 0);
    endtask

    task automatic run_frame(input int m, input string tag);
        int e0;
        e0 = c_exec(m);
        xfer(m);
        chk({tag, "_exec"}, 64'(c_exec(m) - e0), 1);
        chk({tag, "_cmd"}, g_cmd(m), exp_cmd());
    endtask

    task automatic send_word(input int m, input logic [31:0] d, input logic [3:0] v);
        send_data = d; send_valid = v;
        if (m == 0) send_a = 1'b1; else send_b = 1'b1;
        clk_n(1);
        send_a = 1'b0; send_b = 1'b0;
        clk_n(2);
    endtask

    initial begin
        logic [7:0]  mi, r0, r1, r2;
        logic [31:0] d;
        logic [3:0]  v;
        int          m, e0, b0, o0, a0;

        extReset_n = 1'b0; cs_n = 1'b1; mosi = 1'b0; sclk_a = 1'b0; sclk_b = 1'b1;
        send_a = 1'b0; send_b = 1'b0; send_data = '0; send_valid = '0;
        clk_n(5);
        chk("reset_a", {miso_a, execute_a, busy_a, byte_done_a, overrun_a, frame_abort_a, cmd_a}, 0);
        chk("reset_b", {miso_b, execute_b, busy_b, byte_done_b, overrun_b, frame_abort_b, cmd_b}, 0);
        extReset_n = 1'b1; clk_n(5);

        // Reset asserted in the middle of a transfer with tx in flight
        send_word(0, 32'hCAFEF00D, 4'hF);
        chk("busy_after_send", busy_a, 1);
        cs_n = 1'b0; clk_n(4);
        spi_bits(0, 8'hA5, 4, mi);
        #2 extReset_n = 1'b0;
        #1 chk("reset_mid_xfer", {miso_a, execute_a, busy_a, byte_done_a, overrun_a, frame_abort_a, cmd_a}, 0);
        clk_n(1); cs_n = 1'b1; clk_n(3); extReset_n = 1'b1; clk_n(5);

        mo_q = '{8'h02};
        run_frame(0, "short_02");

        // Long frame, execute only after the last byte
        mo_q = '{8'hC0, 8'h11, 8'h22, 8'h33, 8'h44};
        e0 = n_exec_a;
        cs_n = 1'b0; clk_n(4);
        for (int k = 0; k < 4; k++) spi_bits(0, mo_q[k], 8, mi);
        clk_n(HALF);
        chk("no_exec_mid_frame", 64'(n_exec_a - e0), 0);
        spi_bits(0, mo_q[4], 8, mi);
        clk_n(HALF); cs_n = 1'b1; clk_n(8);
        chk("long_exec", 64'(n_exec_a - e0), 1);
        chk("long_cmd", cmd_a, 40'h44332211C0);

        mo_q = '{8'h81, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_frame(3, "mode3_long");

        // Random frames in both modes
        for (int it = 0; it < 8; it++) begin
            m = (it % 2 == 1) ? 3 : 0;
            mo_q.delete();
            r0 = 8'($urandom);
            mo_q.push_back(r0);
            if (r0[7]) for (int k = 0; k < 4; k++) mo_q.push_back(8'($urandom));
            run_frame(m, "rand_frame");
        end

        // send with an empty mask is ignored silently
        o0 = n_ovr_a;
        send_word(0, 32'h55667788, 4'h0);
        chk("empty_mask_busy", busy_a, 0);
        chk("empty_mask_no_overrun", 64'(n_ovr_a - o0), 0);

        // Masked transmit: only bytes 0 and 2 go out
        send_word(0, 32'hAABBCCDD, 4'b0101);
        mo_q = '{8'h01, 8'h02};
        b0 = n_bd_a; e0 = n_exec_a;
        xfer(0);
        chk("tx_mask_byte0", mi_q[0], 8'hDD);
        chk("tx_mask_byte1", mi_q[1], 8'hBB);
        chk("tx_mask_byte_done", 64'(n_bd_a - b0), 2);
        chk("busy_at_first_bd", bd_busy_prev_a, 1);
        chk("busy_at_last_bd", bd_busy_last_a, 0);
        chk("tx_mask_miso_idle", miso_a, 0);
        chk("duplex_exec", 64'(n_exec_a - e0), 2);
        chk("duplex_cmd", cmd_a, 40'h02);

        // Random words in both modes; later ones also hit with an overrun
        for (int it = 0; it < 6; it++) begin
            m = (it % 2 == 1) ? 3 : 0;
            d = $urandom;
            v = 4'($urandom_range(1, 15));
            exp_q.delete();
            for (int k = 0; k < 4; k++) if (v[k]) exp_q.push_back(d[8*k +: 8]);
            send_word(m, d, v);
            if (it >= 2) begin
                o0 = c_ovr(m);
                send_word(m, 32'h12345678, 4'hF);
                chk("overrun_pulse", 64'(c_ovr(m) - o0), 1);
            end
            mo_q.delete();
            foreach (exp_q[k]) mo_q.push_back(8'($urandom) & 8'h7F);
            b0 = c_bd(m); e0 = c_exec(m);
            xfer(m);
            foreach (exp_q[k]) chk("tx_byte", mi_q[k], exp_q[k]);
            chk("tx_byte_done_cnt", 64'(c_bd(m) - b0), 64'(exp_q.size()));
            chk("tx_busy_clear", g_busy(m), 0);
            chk("tx_miso_idle", g_miso(m), 0);
            chk("tx_duplex_exec", 64'(c_exec(m) - e0), 64'(exp_q.size()));
            chk("tx_duplex_cmd", g_cmd(m), {32'h0, mo_q[mo_q.size() - 1]});
        end

        // Deselect after 3 bits of byte 2 of a long frame with tx active
        mo_q = '{8'h33};
        run_frame(0, "pre_abort");
        r0 = 8'($urandom) | 8'h80; r1 = 8'($urandom); r2 = 8'($urandom);
        send_word(0, $urandom, 4'hF);
        a0 = n_abt_a; e0 = n_exec_a;
        cs_n = 1'b0; clk_n(4);
        spi_bits(0, r0, 8, mi);
        spi_bits(0, r1, 8, mi);
        spi_bits(0, r2, 3, mi);
        clk_n(HALF); cs_n = 1'b1; clk_n(8);
        chk("abort_pulse", 64'(n_abt_a - a0), 1);
        chk("abort_no_exec", 64'(n_exec_a - e0), 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_miso", miso_a, 0);
        chk("abort_cmd_kept", cmd_a, 40'h33);
        mo_q = '{8'h9E, 8'h01, 8'h23, 8'h45, 8'h67};
        run_frame(0, "post_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
